apb_timer_periph: RTL and testbench
===================================

Name: apb_timer_periph

Overview:
- APB responder (slave) timer/counter peripheral.
- Sits on one PSELx/PRDATAx/PREADYx slot of the MCU's APB master, beside the RAM, GPIO, FND and UART peripherals.
- Provides a prescaled up-counter, a compare/auto-reload register, a sticky match flag and a level interrupt output.
- Exercises the full APB responder handshake, including wait states on reads.

Parameters:
- WIDTH, 32, counter/compare/prescaler width (1..32); unused upper PRDATA bits read 0.
- READ_WAIT, 1, number of PREADY-low access cycles inserted on reads (0..3); writes always have zero wait states.

Ports:
- PCLK  in  1  clock, all logic on rising edge.
- PRESET  in  1  synchronous, active-low reset.
- PADDR  in  32  byte address; only PADDR[4:2] decoded.
- PWRITE  in  1  1 = write, 0 = read.
- PSEL  in  1  slave select.
- PENABLE  in  1  APB access phase.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, registered.
- PREADY  out  1  transfer completion.
- irq  out  1  match interrupt, level.

Behaviour:

Register map (index = PADDR[4:2]):
- 0 TCR: bit0 EN, bit1 CLR (write-1 pulse, reads 0), bit2 IRQ_EN, bit3 AUTO_RELOAD.
- 1 TCNT: counter, R/W; a write loads the counter.
- 2 PSC: prescaler, R/W.
- 3 ARR: compare/reload, R/W.
- 4 TSR: bit0 MATCH, sticky, write-1-to-clear.
- 5..7: read 0, writes ignored.

Reset (PRESET=0 at a PCLK edge):
- All registers, prescale counter, PRDATA, PREADY and irq go to 0.
- FSM goes to IDLE.
- Reset during an APB transfer aborts it; no register is written.

APB FSM (states IDLE, SETUP, WAIT, DONE):
- IDLE -> SETUP when PSEL=1 and PENABLE=0.
- SETUP -> DONE when PENABLE=1 and (PWRITE=1 or READ_WAIT=0).
- SETUP -> WAIT when PENABLE=1, PWRITE=0 and READ_WAIT>0. WAIT counts READ_WAIT cycles, then -> DONE.
- In DONE, PREADY=1 for exactly one cycle, then -> IDLE, or -> SETUP if PSEL=1 and PENABLE=0.
- PREADY=0 in every state except DONE.
- PSEL deasserted in any state returns the FSM to IDLE with PREADY=0.
- Writes commit on the edge closing the DONE cycle (PSEL & PENABLE & PWRITE & PREADY).
- Read data is captured into PRDATA on the edge entering DONE, so it is valid while PREADY=1. PRDATA holds its value otherwise.
- Back-to-back transfers: minimum 2 cycles per write (SETUP + DONE) and 2+READ_WAIT cycles per read.

Counter:
- The prescale counter runs only while EN=1. At pcnt==PSC: pcnt<=0 and one tick is generated; otherwise pcnt++.
- PSC=0 means one tick per PCLK.
- On a tick:
  - If TCNT==ARR: TCNT<=0 and MATCH<=1; if AUTO_RELOAD=0, EN<=0 (one-shot).
  - Otherwise TCNT<=TCNT+1. Wraps modulo 2^WIDTH if ARR is below the current TCNT.
- EN=0: TCNT and pcnt hold.
- irq = MATCH & IRQ_EN, driven from registers and glitch-free.

Priorities when events coincide in the same cycle:
- CLR write beats tick: TCNT<=0 and pcnt<=0. Other TCR bits take their written values.
- TCNT write beats tick increment/reload; the match check for that tick is skipped.
- PSC write resets pcnt to 0.
- TSR W1C and a MATCH set in the same cycle: the set wins, MATCH stays 1.
- TCR write clearing EN beats a one-shot auto-clear; the result is the same.

Width rules: written values are truncated to WIDTH bits; reads are zero-extended.

Test Plan:
- Reset: hold PRESET=0 for 2 cycles with PSEL=1 -> PREADY=0, PRDATA=0, irq=0; every register reads 0 afterwards.
- APB timing: write ARR=0x1234, then read it with READ_WAIT=1 -> the write has PREADY high in its first access cycle. The read has PREADY low for 1 access cycle, then high with PRDATA=0x1234. Reading index 6 returns 0.
- Prescale/auto-reload: PSC=3, ARR=4, TCR=0b1101 -> TCNT increments every 4 cycles, 0..4 then 0. MATCH sets and irq rises on the wrap, 20 cycles after enable. Counting continues.
- One-shot: ARR=2, PSC=0, TCR=0b0001 -> MATCH=1 after 3 ticks; EN reads 0 and TCNT stays 0.
- Collisions: W1C of TSR in the same cycle as a match -> MATCH stays 1. TCNT write 0x10 on a tick cycle -> TCNT reads 0x10, not 0x11.
- Mid-transfer reset: assert PRESET=0 during WAIT of a read -> PREADY=0, FSM IDLE; the next read completes normally.

Source files
------------

// File: rtl/apb_timer_periph_if.sv
// APB bus bundle for the timer slot: address/control/write data from the master,
// read data and ready from the responder.
interface apb_timer_periph_if;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   modport master (
      output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
      output PRDATA, PREADY
   );
endinterface

// File: rtl/apb_timer_periph.sv
// APB timer: prescaled up-counter with compare/auto-reload, sticky match flag and level irq.
// Writes complete in the first access cycle; reads stall PREADY for READ_WAIT access cycles.
module apb_timer_periph #(
   parameter int WIDTH     = 32,
   parameter int READ_WAIT = 1
) (
   input  logic                PCLK,
   input  logic                PRESET,
   apb_timer_periph_if.slave   apb,
   output logic                irq
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] IDX_TCR  = 3'd0;
   localparam logic [2:0] IDX_TCNT = 3'd1;
   localparam logic [2:0] IDX_PSC  = 3'd2;
   localparam logic [2:0] IDX_ARR  = 3'd3;
   localparam logic [2:0] IDX_TSR  = 3'd4;

   localparam logic [1:0] WAIT_LAST = 2'((READ_WAIT == 0) ? 0 : READ_WAIT - 1);

   state_t            state_q, state_d, state_cur;
   logic [1:0]        wcnt_q, wcnt_d;
   logic [31:0]       prdata_q, prdata_d;
   logic              rd_capture;

   logic              en_q, en_d;
   logic              ien_q, ien_d;
   logic              ar_q, ar_d;
   logic              match_q, match_d;
   logic              irq_q, irq_d;
   logic [WIDTH-1:0]  tcnt_q, tcnt_d;
   logic [WIDTH-1:0]  psc_q, psc_d;
   logic [WIDTH-1:0]  arr_q, arr_d;
   logic [WIDTH-1:0]  pcnt_q, pcnt_d;

   logic              pready;
   logic [2:0]        idx;
   logic [WIDTH-1:0]  wdat;
   logic              wr_en, wr_tcr, wr_tcnt, wr_psc, wr_arr, wr_tsr, clr;
   logic              tick, hit;
   logic [31:0]       rdata;
   logic              unused_bits;

   assign idx    = apb.PADDR[4:2];
   assign wdat   = apb.PWDATA[WIDTH-1:0];
   assign pready = (state_q == ST_DONE);

   assign apb.PREADY = pready;
   assign apb.PRDATA = prdata_q;
   assign irq        = irq_q;

   assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA};

   // The setup cycle is decoded from the bus rather than registered, so the
   // decision to stall is already made when the access cycle begins.
   always_comb begin
      state_cur  = state_q;
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      rd_capture = 1'b0;
      if (apb.PSEL && !apb.PENABLE && (state_q != ST_WAIT)) begin
         state_cur = ST_SETUP;
      end
      case (state_cur)
         ST_IDLE: state_d = ST_IDLE;
         ST_SETUP: begin
            wcnt_d = 2'd0;
            if (apb.PWRITE || (READ_WAIT == 0)) begin
               state_d    = ST_DONE;
               rd_capture = !apb.PWRITE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wcnt_q == WAIT_LAST) begin
               state_d    = ST_DONE;
               rd_capture = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 2'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (!apb.PSEL) begin
         state_d    = ST_IDLE;
         rd_capture = 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      case (idx)
         IDX_TCR:  rdata[3:0]       = {ar_q, ien_q, 1'b0, en_q};
         IDX_TCNT: rdata[WIDTH-1:0] = tcnt_q;
         IDX_PSC:  rdata[WIDTH-1:0] = psc_q;
         IDX_ARR:  rdata[WIDTH-1:0] = arr_q;
         IDX_TSR:  rdata[0]         = match_q;
         default:  rdata            = '0;
      endcase
      prdata_d = rd_capture ? rdata : prdata_q;
   end

   assign wr_en   = apb.PSEL && apb.PENABLE && apb.PWRITE && pready;
   assign wr_tcr  = wr_en && (idx == IDX_TCR);
   assign wr_tcnt = wr_en && (idx == IDX_TCNT);
   assign wr_psc  = wr_en && (idx == IDX_PSC);
   assign wr_arr  = wr_en && (idx == IDX_ARR);
   assign wr_tsr  = wr_en && (idx == IDX_TSR);
   assign clr     = wr_tcr && apb.PWDATA[1];

   // A same-cycle TCNT load or clear overrides the tick, including its match.
   assign tick = en_q && (pcnt_q == psc_q);
   assign hit  = tick && (tcnt_q == arr_q) && !wr_tcnt && !clr;

   always_comb begin
      pcnt_d  = pcnt_q;
      tcnt_d  = tcnt_q;
      psc_d   = psc_q;
      arr_d   = arr_q;
      en_d    = en_q;
      ien_d   = ien_q;
      ar_d    = ar_q;
      match_d = match_q;

      if (en_q) begin
         pcnt_d = (pcnt_q == psc_q) ? '0 : pcnt_q + WIDTH'(1);
      end
      if (tick) begin
         tcnt_d = (tcnt_q == arr_q) ? '0 : tcnt_q + WIDTH'(1);
      end
      if (hit && !ar_q) begin
         en_d = 1'b0;
      end

      if (wr_tcr) begin
         en_d  = apb.PWDATA[0];
         ien_d = apb.PWDATA[2];
         ar_d  = apb.PWDATA[3];
      end
      if (clr) begin
         tcnt_d = '0;
         pcnt_d = '0;
      end
      if (wr_tcnt) tcnt_d = wdat;
      if (wr_psc) begin
         psc_d  = wdat;
         pcnt_d = '0;
      end
      if (wr_arr) arr_d = wdat;

      if (wr_tsr && apb.PWDATA[0]) match_d = 1'b0;
      if (hit) match_d = 1'b1;

      irq_d = match_d && ien_d;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         state_q  <= ST_IDLE;
         wcnt_q   <= 2'd0;
         prdata_q <= '0;
         en_q     <= 1'b0;
         ien_q    <= 1'b0;
         ar_q     <= 1'b0;
         match_q  <= 1'b0;
         irq_q    <= 1'b0;
         tcnt_q   <= '0;
         psc_q    <= '0;
         arr_q    <= '0;
         pcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         prdata_q <= prdata_d;
         en_q     <= en_d;
         ien_q    <= ien_d;
         ar_q     <= ar_d;
         match_q  <= match_d;
         irq_q    <= irq_d;
         tcnt_q   <= tcnt_d;
         psc_q    <= psc_d;
         arr_q    <= arr_d;
         pcnt_q   <= pcnt_d;
      end
   end

endmodule

// File: tb/tb_apb_timer_periph.sv
// Bench for apb_timer_periph: APB master tasks plus an arithmetic timer model
// (tick count from elapsed edges) against randomized prescaler/compare settings.
module tb_apb_timer_periph;
   localparam int RW = 1;

   logic PCLK = 1'b0;
   logic PRESET;
   logic irq;

   apb_timer_periph_if bus ();

   apb_timer_periph #(.WIDTH(32), .READ_WAIT(RW)) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .apb    (bus),
      .irq    (irq)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic apb_write(input logic [2:0] idx, input logic [31:0] d,
                            output int waits, output int commit);
      bus.PADDR = {27'd0, idx, 2'b00};
      bus.PWRITE = 1'b1; bus.PWDATA = d; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      waits = 0;
      while (bus.PREADY !== 1'b1 && waits < 10) begin
         @(posedge PCLK); #1; waits++;
      end
      commit = cyc + 1;
      n_chk++;
      if (bus.PREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL write_timeout idx=%0d: PREADY=%b, required 1 within 10 cycles", idx, bus.PREADY);
      end
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] idx, output logic [31:0] d,
                           output int waits, output int capture);
      bus.PADDR = {27'd0, idx, 2'b00};
      bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      waits = 0;
      while (bus.PREADY !== 1'b1 && waits < 10) begin
         @(posedge PCLK); #1; waits++;
      end
      capture = cyc;
      d = bus.PRDATA;
      n_chk++;
      if (bus.PREADY !== 1'b1) begin
         n_fail++;
         $display("FAIL read_timeout idx=%0d: PREADY=%b, required 1 within 10 cycles", idx, bus.PREADY);
      end
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   task automatic stop_and_clear();
      int w, c;
      apb_write(3'd0, 32'h2, w, c);
      apb_write(3'd4, 32'h1, w, c);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int w, c;
      PRESET = 1'b0;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0; bus.PWDATA = '0;
      repeat (2) begin @(posedge PCLK); #1; end
      n_chk++;
      if (bus.PREADY !== 1'b0 || bus.PRDATA !== 32'h0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: PREADY=%b PRDATA=%h irq=%b, required 0/0/0", bus.PREADY, bus.PRDATA, irq);
      end
      PRESET = 1'b1;
      bus.PSEL = 1'b0;
      @(posedge PCLK); #1;
      for (int i = 0; i < 8; i++) begin
         apb_read(3'(i), d, w, c);
         n_chk++;
         if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_reg idx=%0d: read %h, required 0", i, d);
         end
      end
   endtask

   task automatic test_apb_timing();
      logic [31:0] d;
      int w, c;
      apb_write(3'd3, 32'h1234, w, c);
      n_chk++;
      if (w !== 0) begin
         n_fail++;
         $display("FAIL write_waits: %0d wait cycles, required 0", w);
      end
      apb_read(3'd3, d, w, c);
      n_chk++;
      if (w !== RW || d !== 32'h1234) begin
         n_fail++;
         $display("FAIL read_arr: waits=%0d data=%h, required waits=%0d data=00001234", w, d, RW);
      end
      apb_write(3'd6, 32'hFFFF_FFFF, w, c);
      apb_read(3'd6, d, w, c);
      n_chk++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL read_idx6: read %h, required 0", d);
      end
      apb_write(3'd0, 32'hFFFF_FFFE, w, c);
      apb_read(3'd0, d, w, c);
      n_chk++;
      if (d !== 32'hC) begin
         n_fail++;
         $display("FAIL tcr_fields: read %h, required 0000000c", d);
      end
      apb_write(3'd0, 32'h0, w, c);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int w, c1, c2;
      apb_write(3'd2, 32'h7, w, c1);
      apb_write(3'd3, 32'h9, w, c2);
      n_chk++;
      if (c2 - c1 !== 2) begin
         n_fail++;
         $display("FAIL b2b_write: spacing %0d cycles, required 2", c2 - c1);
      end
      apb_read(3'd2, d, w, c1);
      apb_read(3'd3, d, w, c2);
      n_chk++;
      if (c2 - c1 !== 2 + RW || d !== 32'h9) begin
         n_fail++;
         $display("FAIL b2b_read: spacing %0d data %h, required %0d and 00000009", c2 - c1, d, 2 + RW);
      end
   endtask

   task automatic test_prescale();
      logic [31:0] d;
      int w, c, ec, seen, ticks;
      stop_and_clear();
      apb_write(3'd2, 32'd3, w, c);
      apb_write(3'd3, 32'd4, w, c);
      apb_write(3'd0, 32'hD, w, ec);
      seen = -1;
      for (int i = 0; i < 60 && seen < 0; i++) begin
         if (irq === 1'b1) seen = cyc;
         else begin @(posedge PCLK); #1; end
      end
      n_chk++;
      if (seen - ec !== 20) begin
         n_fail++;
         $display("FAIL prescale_irq_time: irq rose %0d cycles after enable, required 20", seen - ec);
      end
      apb_read(3'd4, d, w, c);
      n_chk++;
      if (d !== 32'h1) begin
         n_fail++;
         $display("FAIL prescale_match: TSR %h, required 1", d);
      end
      apb_read(3'd1, d, w, c);
      ticks = (c - 1 - ec) / 4;
      n_chk++;
      if (d !== 32'(ticks % 5)) begin
         n_fail++;
         $display("FAIL prescale_tcnt: TCNT %h, required %h", d, ticks % 5);
      end
      apb_read(3'd0, d, w, c);
      n_chk++;
      if (d !== 32'hD) begin
         n_fail++;
         $display("FAIL prescale_tcr: TCR %h, required 0000000d", d);
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      int w, c, ec, p, a, ar, dly, ticks, exp_cnt, exp_m;
      for (int it = 0; it < 8; it++) begin
         p   = $urandom_range(0, 3);
         a   = $urandom_range(1, 7);
         ar  = $urandom_range(0, 1);
         dly = $urandom_range(0, 30);
         stop_and_clear();
         apb_write(3'd2, 32'(p), w, c);
         apb_write(3'd3, 32'(a), w, c);
         apb_write(3'd0, (ar != 0) ? 32'hD : 32'h5, w, ec);
         repeat (dly) begin @(posedge PCLK); #1; end
         apb_read(3'd1, d, w, c);
         ticks = (c - 1 - ec) / (p + 1);
         if (ar != 0) exp_cnt = ticks % (a + 1);
         else         exp_cnt = (ticks >= a + 1) ? 0 : ticks;
         n_chk++;
         if (d !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL rand_tcnt it=%0d psc=%0d arr=%0d ar=%0d: TCNT %0d, required %0d", it, p, a, ar, d, exp_cnt);
         end
         apb_read(3'd4, d, w, c);
         exp_m = (((c - 1 - ec) / (p + 1)) >= a + 1) ? 1 : 0;
         n_chk++;
         if (d !== 32'(exp_m)) begin
            n_fail++;
            $display("FAIL rand_match it=%0d: TSR %0d, required %0d", it, d, exp_m);
         end
         exp_m = (((c - ec) / (p + 1)) >= a + 1) ? 1 : 0;
         n_chk++;
         if (irq !== exp_m[0]) begin
            n_fail++;
            $display("FAIL rand_irq it=%0d: irq %b, required %0d", it, irq, exp_m);
         end
      end
   endtask

   task automatic test_one_shot();
      logic [31:0] d;
      int w, c, ec;
      stop_and_clear();
      apb_write(3'd2, 32'd0, w, c);
      apb_write(3'd3, 32'd2, w, c);
      apb_write(3'd0, 32'h1, w, ec);
      repeat (10) begin @(posedge PCLK); #1; end
      apb_read(3'd4, d, w, c);
      n_chk++;
      if (d !== 32'h1) begin
         n_fail++;
         $display("FAIL oneshot_match: TSR %h, required 1", d);
      end
      apb_read(3'd0, d, w, c);
      n_chk++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL oneshot_en: TCR %h, required 0", d);
      end
      apb_read(3'd1, d, w, c);
      n_chk++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_tcnt: TCNT %h irq %b, required 0 and 0", d, irq);
      end
   endtask

   task automatic test_collisions();
      logic [31:0] d;
      int w, c, ec;
      stop_and_clear();
      apb_write(3'd2, 32'd0, w, c);
      apb_write(3'd3, 32'd9, w, c);
      apb_write(3'd0, 32'h9, w, ec);
      while (cyc < ec + 8) begin @(posedge PCLK); #1; end
      apb_write(3'd4, 32'h1, w, c);
      n_chk++;
      if (c !== ec + 10) begin
         n_fail++;
         $display("FAIL w1c_align: commit at +%0d, required +10", c - ec);
      end
      apb_read(3'd4, d, w, c);
      n_chk++;
      if (d !== 32'h1) begin
         n_fail++;
         $display("FAIL w1c_vs_match: TSR %h, required 1", d);
      end
      apb_write(3'd4, 32'h1, w, c);
      apb_read(3'd4, d, w, c);
      n_chk++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL w1c_plain: TSR %h, required 0", d);
      end

      stop_and_clear();
      apb_write(3'd2, 32'd3, w, c);
      apb_write(3'd3, 32'd1, w, c);
      apb_write(3'd0, 32'h9, w, ec);
      while (cyc < ec + 6) begin @(posedge PCLK); #1; end
      apb_write(3'd1, 32'h10, w, c);
      apb_write(3'd0, 32'h0, w, c);
      apb_read(3'd1, d, w, c);
      n_chk++;
      if (d !== 32'h10) begin
         n_fail++;
         $display("FAIL tcnt_vs_tick: TCNT %h, required 00000010", d);
      end
      apb_read(3'd4, d, w, c);
      n_chk++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL tcnt_write_skips_match: TSR %h, required 0", d);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] d;
      int w, c;
      apb_write(3'd3, 32'h77, w, c);
      bus.PADDR = {27'd0, 3'd3, 2'b00};
      bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      PRESET = 1'b0;
      @(posedge PCLK); #1;
      n_chk++;
      if (bus.PREADY !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_pready: PREADY %b, required 0", bus.PREADY);
      end
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      n_chk++;
      if (bus.PREADY !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_idle: PREADY %b, required 0", bus.PREADY);
      end
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      apb_read(3'd3, d, w, c);
      n_chk++;
      if (d !== 32'h0 || w !== RW) begin
         n_fail++;
         $display("FAIL midreset_next_read: data %h waits %0d, required 0 and %0d", d, w, RW);
      end
      apb_write(3'd3, 32'h55, w, c);
      apb_read(3'd3, d, w, c);
      n_chk++;
      if (d !== 32'h55) begin
         n_fail++;
         $display("FAIL midreset_readback: ARR %h, required 00000055", d);
      end
   endtask

   initial begin
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0; bus.PWDATA = '0;
      PRESET = 1'b0;
      @(posedge PCLK); #1;
      test_reset();
      test_apb_timing();
      test_back_to_back();
      test_prescale();
      test_random();
      test_one_shot();
      test_collisions();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
